fixed_alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's single-shot fixed-point ALU. It performs signed Qm.FRAC arithmetic of configurable width with an iterative multi-cycle divider, valid/ready flow control on both sides and optional saturation. It sits between the calculator's operand/opcode decoder and its result formatter, and it stalls the upstream side while a division runs or the downstream side withholds ready.

---
 rtl/fixed_alu_seq_if.sv | 27 ++
 rtl/fixed_alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_fixed_alu_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_alu_seq_if.sv
// fixed_alu_seq_if: operand/opcode request and result/flag response bundle
// for the sequential fixed-point ALU. master = upstream driver, slave = ALU.
interface fixed_alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, operand_a, operand_b, operation, out_ready,
    input  in_ready, out_valid, result, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, operand_a, operand_b, operation, out_ready,
    output in_ready, out_valid, result, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_alu_seq.sv
// fixed_alu_seq: handshaked signed Q(WIDTH-FRAC).FRAC ALU with an iterative
// restoring divider (one quotient bit per cycle, WIDTH+FRAC cycles).
// Optional saturation on overflow: define FIXED_ALU_SAT_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid; captures operands and opcode
// EXEC  | evaluates non-DIV ops / DIV-by-zero, or loads the divider
// DIV   | restoring division in progress, cnt counts down to 0
// DONE  | out_valid=1, result and flags held until out_ready
module fixed_alu_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 14
) (
  input logic           clk,
  input logic           reset,
  fixed_alu_seq_if.slave bus
);
  localparam int QW = WIDTH + FRAC;
  localparam int CW = $clog2(QW);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MIN = 4'd4;
  localparam logic [3:0] OP_MAX = 4'd5;
  localparam logic [3:0] OP_ABS = 4'd6;
  localparam logic [3:0] OP_NEG = 4'd7;

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  // quotient magnitude limits, widened to the quotient register width
  localparam logic [QW-1:0] Q_POS_LIM = {{FRAC{1'b0}}, MAX_V};
  localparam logic [QW-1:0] Q_NEG_LIM = {{FRAC{1'b0}}, MIN_V};

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [QW-1:0]    quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             div_by_zero_q;
  logic             out_valid_q;

  logic [WIDTH:0]          add_x, sub_x;
  logic signed [2*WIDTH-1:0] prod_x, mul_sh;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic                    b_zero;
  logic [WIDTH-1:0]        exec_res;
  logic                    exec_ovf, exec_neg;
  logic [WIDTH-1:0]        dbz_res;

  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [QW-1:0]    quo_nxt;
  logic             div_ovf;
  logic [WIDTH-1:0] div_res;

  // on overflow, clamp toward the sign of the exact value when saturating
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] res,
                                             input logic ovf, input logic neg);
`ifdef FIXED_ALU_SAT_EN
    if (ovf) return neg ? MIN_V : MAX_V;
`endif
    return res;
  endfunction

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = div_by_zero_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = EXEC;
      EXEC: state_nxt = (op_q == OP_DIV && !b_zero) ? DIV : DONE;
      DIV:  if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // single-cycle ops: exact value, overflow test and sign of the exact value
  always_comb begin
    add_x    = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    sub_x    = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    prod_x   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    mul_sh   = prod_x >>> FRAC;
    mag_a    = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
    mag_b    = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
    b_zero   = (b_q == '0);
    exec_res = '0;
    exec_ovf = 1'b0;
    exec_neg = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = add_x[WIDTH-1:0];
        exec_ovf = add_x[WIDTH] ^ add_x[WIDTH-1];
        exec_neg = add_x[WIDTH];
      end
      OP_SUB: begin
        exec_res = sub_x[WIDTH-1:0];
        exec_ovf = sub_x[WIDTH] ^ sub_x[WIDTH-1];
        exec_neg = sub_x[WIDTH];
      end
      OP_MUL: begin
        exec_res = mul_sh[WIDTH-1:0];
        exec_ovf = !((&mul_sh[2*WIDTH-1:WIDTH-1]) || !(|mul_sh[2*WIDTH-1:WIDTH-1]));
        exec_neg = mul_sh[2*WIDTH-1];
      end
      OP_MIN: exec_res = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
      OP_MAX: exec_res = ($signed(a_q) < $signed(b_q)) ? b_q : a_q;
      OP_ABS: begin
        exec_res = mag_a;
        exec_ovf = (a_q == MIN_V);
      end
      OP_NEG: begin
        exec_res = ~a_q + 1'b1;
        exec_ovf = (a_q == MIN_V);
      end
      default: exec_res = '0;
    endcase
`ifdef FIXED_ALU_SAT_EN
    dbz_res = (a_q == '0) ? '0 : (a_q[WIDTH-1] ? MIN_V : MAX_V);
`else
    dbz_res = '0;
`endif
  end

  // one restoring-division step plus the final sign/range fix-up
  always_comb begin
    rem_sh  = {rem, quo[QW-1]};
    div_ge  = (rem_sh >= {1'b0, dvs});
    rem_nxt = div_ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[QW-2:0], div_ge};
    div_ovf = q_neg ? (quo_nxt > Q_NEG_LIM) : (quo_nxt > Q_POS_LIM);
    div_res = q_neg ? (~quo_nxt[WIDTH-1:0] + 1'b1) : quo_nxt[WIDTH-1:0];
  end

  // operand capture, divider iteration and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      q_neg         <= 1'b0;
      cnt           <= '0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q           <= bus.operand_a;
            b_q           <= bus.operand_b;
            op_q          <= bus.operation;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
          end
        end
        EXEC: begin
          if (op_q == OP_DIV) begin
            if (b_zero) begin
              result_q      <= dbz_res;
              div_by_zero_q <= 1'b1;
              overflow_q    <= 1'b0;
            end else begin
              quo   <= {mag_a, {FRAC{1'b0}}};
              rem   <= '0;
              dvs   <= mag_b;
              q_neg <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
              cnt   <= CW'(QW - 1);
            end
          end else begin
            result_q   <= clamp(exec_res, exec_ovf, exec_neg);
            overflow_q <= exec_ovf;
          end
        end
        DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result_q   <= clamp(div_res, div_ovf, q_neg);
            overflow_q <= div_ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_alu_seq.sv
// tb_fixed_alu_seq: directed and randomized operations against a wide-integer
// arithmetic model of the fixed-point ALU, with handshake timing checks.
module tb_fixed_alu_seq;
  localparam int W  = 32;
  localparam int F  = 14;
  localparam int QW = W + F;

  localparam logic signed [127:0] MAXV = (128'sd1 <<< (W-1)) - 128'sd1;
  localparam logic signed [127:0] MINV = -(128'sd1 <<< (W-1));

`ifdef FIXED_ALU_SAT_EN
  localparam logic [W-1:0] ADD_OVF_RES = 32'h7FFF_FFFF;
  localparam logic [W-1:0] DBZ_RES     = 32'h7FFF_FFFF;
`else
  localparam logic [W-1:0] ADD_OVF_RES = 32'h8000_3FFF;
  localparam logic [W-1:0] DBZ_RES     = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fixed_alu_seq_if #(.WIDTH(W), .FRAC(F)) bus ();
  fixed_alu_seq #(.WIDTH(W), .FRAC(F)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exact arithmetic on wide signed integers, then range check / wrap / clamp
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic ovf, output logic dbz);
    logic signed [127:0] sa, sb, ex;
    sa  = $signed(a);
    sb  = $signed(b);
    ex  = 0;
    dbz = 1'b0;
    case (op)
      4'd0: ex = sa + sb;
      4'd1: ex = sa - sb;
      4'd2: ex = (sa * sb) >>> F;
      4'd3: if (sb == 0) dbz = 1'b1; else ex = (sa <<< F) / sb;
      4'd4: ex = (sa < sb) ? sa : sb;
      4'd5: ex = (sa < sb) ? sb : sa;
      4'd6: ex = (sa < 0) ? -sa : sa;
      4'd7: ex = -sa;
      default: ex = 0;
    endcase
    ovf = (ex > MAXV) || (ex < MINV);
    res = ex[W-1:0];
`ifdef FIXED_ALU_SAT_EN
    if (ovf) res = (ex < 0) ? MINV[W-1:0] : MAXV[W-1:0];
    if (dbz) res = (sa == 0) ? '0 : ((sa < 0) ? MINV[W-1:0] : MAXV[W-1:0]);
`endif
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = MINV[W-1:0];
      2: v = MAXV[W-1:0];
      3: v = W'(1) << F;
      4: v = '1;
      5: v = rnd() >>> $urandom_range(0, W-1);
      default: v = rnd();
    endcase
    return v;
  endfunction

  // issue one op, check latency/result/flags, optional backpressure, consume
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit early, input bit has_exp,
                        input logic [W-1:0] exp_c);
    logic [W-1:0] er;
    logic eo, ed;
    int k;
    bit seen;
    model(op, a, b, er, eo, ed);
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.out_ready = early;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.operand_a = rnd();
    bus.operand_b = rnd();
    bus.operation = 4'($urandom_range(0, 15));
    k    = 0;
    seen = 1'b0;
    while (!seen && k < QW + 10) begin
      @(negedge clk);
      k++;
      seen = bus.out_valid;
    end
    chk("out_valid_seen", seen, 1);
    if (!seen) return;
    chk("latency", k, (op == 4'd3 && b != '0) ? 2 + QW : 2);
    chk("result", bus.result, er);
    chk("overflow", bus.overflow, eo);
    chk("div_by_zero", bus.div_by_zero, ed);
    if (has_exp) chk("result_const", bus.result, exp_c);
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        bus.in_valid  = 1'b1;
        bus.operand_a = rnd();
        bus.operand_b = rnd();
        bus.operation = 4'($urandom_range(0, 15));
        @(negedge clk);
        chk("hold_result", bus.result, er);
        chk("hold_overflow", bus.overflow, eo);
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_in_ready", bus.in_ready, 0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after", bus.in_ready, 1);
    chk("valid_after", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.operation = '0;
    reset = 1'b1;
    #23;
    chk("rst_result", bus.result, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'd2, 32'h0000_6000, 32'h0000_8000, 0, 1'b1, 1'b1, 32'h0000_C000);
    run_op(4'd3, 32'h0000_C000, 32'h0000_8000, 0, 1'b0, 1'b1, 32'h0000_6000);
    run_op(4'd3, 32'hFFFF_4000, 32'h0000_8000, 1, 1'b0, 1'b1, 32'hFFFF_A000);
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_4000, 0, 1'b1, 1'b1, ADD_OVF_RES);
    run_op(4'd3, 32'h0000_4000, 32'h0000_0000, 0, 1'b0, 1'b1, DBZ_RES);
    run_op(4'd6, 32'h8000_0000, 32'h0000_0000, 0, 1'b1, 1'b0, '0);
    run_op(4'd7, 32'h8000_0000, 32'h0000_0000, 0, 1'b1, 1'b0, '0);
    run_op(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b1, 1'b0, '0);
    run_op(4'd1, 32'h1234_5678, 32'h0000_1000, 10, 1'b0, 1'b0, '0);

    // reset in the middle of a division
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_4000, 0, 1'b1, 1'b0, '0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = 4'd3;
    bus.operand_a = 32'h0000_C000;
    bus.operand_b = 32'h0000_8000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    chk("div_busy_in_ready", bus.in_ready, 0);
    reset = 1'b1;
    #1;
    chk("arst_result", bus.result, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_dbz", bus.div_by_zero, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd0, 32'h0000_4000, 32'h0000_4000, 0, 1'b1, 1'b1, 32'h0000_8000);

    for (int n = 0; n < 150; n++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
